// File: rtl/ram_loader.sv
// Boot-time program loader: byte stream -> big-endian 16-bit words -> consecutive RAM writes, CPU held meanwhile.
// Latency: 3 cycles per word minimum (high accept, low accept, write); done pulses 1 cycle after the last write.
// Backpressure: in_ready is high only in the four byte-accepting states; a stalled stream simply parks the FSM.
//
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   start             - one-cycle load request, only honoured while idle
//   in_data/in_valid/in_ready - byte stream handshake (accept = in_valid && in_ready)
//   ram_address/ram_data/ram_wren - single-port RAM write side
//   cpu_hold, busy    - high for the whole load, including the done cycle
//   done              - one-cycle completion pulse
//   checksum          - XOR of every word written by the most recent load
module ram_loader #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_address,
  output logic [15:0]       ram_data,
  output logic              ram_wren,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [15:0]       checksum
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_HI  = 3'd1,
    S_LEN_LO  = 3'd2,
    S_DATA_HI = 3'd3,
    S_DATA_LO = 3'd4,
    S_WRITE   = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t      state_q, state_nxt;
  logic [15:0] count_q;
  logic [15:0] len_q;
  logic [7:0]  hi_q;
  logic [15:0] count_inc;
  logic        accept;

  assign accept    = in_valid && in_ready;
  assign count_inc = count_q + 16'd1;
  assign cpu_hold  = busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    in_ready  = 1'b0;
    ram_wren  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        in_ready = 1'b1;
        // The length register only holds the high byte yet, so the
        // zero test uses the byte being accepted for the low half.
        if (in_valid) state_nxt = ({len_q[15:8], in_data} == 16'd0) ? S_DONE : S_DATA_HI;
      end
      S_DATA_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_DATA_LO;
      end
      S_DATA_LO: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        ram_wren  = 1'b1;
        state_nxt = (count_inc == len_q) ? S_DONE : S_DATA_HI;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: address/data/checksum are registers so they hold between
  // writes and stay stable after done until the next start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q     <= '0;
      len_q       <= '0;
      hi_q        <= '0;
      ram_address <= BASE_ADDR;
      ram_data    <= '0;
      checksum    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            count_q     <= '0;
            checksum    <= '0;
            ram_address <= BASE_ADDR;
          end
        end
        S_LEN_HI:  if (accept) len_q[15:8] <= in_data;
        S_LEN_LO:  if (accept) len_q[7:0]  <= in_data;
        S_DATA_HI: if (accept) hi_q        <= in_data;
        S_DATA_LO: if (accept) ram_data    <= {hi_q, in_data};
        S_WRITE: begin
          checksum    <= checksum ^ ram_data;
          ram_address <= ram_address + ADDR_ONE;  // wraps modulo 2^ADDR_W
          count_q     <= count_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: two instances (16-bit address at base 0, 4-bit address at base 14),
// streams driven with random gaps and stray start pulses, results checked against a
// reference computed directly from the byte stream (length header, big-endian words).
module tb_ram_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_start, a_valid, a_ready, a_wren, a_hold, a_busy, a_done;
  logic [7:0]  a_in;
  logic [15:0] a_addr, a_rdat, a_ck;

  logic        b_start, b_valid, b_ready, b_wren, b_hold, b_busy, b_done;
  logic [7:0]  b_in;
  logic [3:0]  b_addr;
  logic [15:0] b_rdat, b_ck;

  ram_loader #(.ADDR_W(16), .BASE_ADDR(16'h0000)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .in_data(a_in), .in_valid(a_valid),
    .in_ready(a_ready), .ram_address(a_addr), .ram_data(a_rdat), .ram_wren(a_wren),
    .cpu_hold(a_hold), .busy(a_busy), .done(a_done), .checksum(a_ck)
  );

  ram_loader #(.ADDR_W(4), .BASE_ADDR(4'd14)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .in_data(b_in), .in_valid(b_valid),
    .in_ready(b_ready), .ram_address(b_addr), .ram_data(b_rdat), .ram_wren(b_wren),
    .cpu_hold(b_hold), .busy(b_busy), .done(b_done), .checksum(b_ck)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Edge counter: when read at a falling edge it numbers the rising edge just passed.
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Write/done/hold observers, sampled on the falling edge.
  int qa0[$], qd0[$], qa1[$], qd1[$];
  int ndone[2], done_cyc[2], fall_cyc[2], wren_cyc[2], bad_rdy[2];
  bit hold_prev[2];

  always @(negedge clk) begin
    if (a_wren) begin
      qa0.push_back(int'(a_addr)); qd0.push_back(int'(a_rdat));
      wren_cyc[0] = cyc;
      if (a_ready) bad_rdy[0]++;
    end
    if (a_done) begin ndone[0]++; done_cyc[0] = cyc; end
    if (hold_prev[0] && !a_hold) fall_cyc[0] = cyc;
    hold_prev[0] = a_hold;
    if (b_wren) begin
      qa1.push_back(int'(b_addr)); qd1.push_back(int'(b_rdat));
      wren_cyc[1] = cyc;
      if (b_ready) bad_rdy[1]++;
    end
    if (b_done) begin ndone[1]++; done_cyc[1] = cyc; end
    if (hold_prev[1] && !b_hold) fall_cyc[1] = cyc;
    hold_prev[1] = b_hold;
  end

  task automatic drv(input int sel, input logic st, input logic v, input logic [7:0] d);
    if (sel == 0) begin a_start = st; a_valid = v; a_in = d; end
    else          begin b_start = st; b_valid = v; b_in = d; end
  endtask

  function automatic logic rdy_of(input int sel);
    return (sel != 0) ? b_ready : a_ready;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel != 0) ? b_busy : a_busy;
  endfunction

  function automatic int nwr_of(input int sel);
    return (sel != 0) ? qa1.size() : qa0.size();
  endfunction

  task automatic mk_stream(input int n, output logic [7:0] s[$]);
    s = {};
    s.push_back(8'(n >> 8));
    s.push_back(8'(n));
    for (int i = 0; i < 2 * n; i++) s.push_back(8'($urandom));
  endtask

  // Runs one full load on instance sel and checks it against the stream.
  // gap: percent chance of an idle cycle; stray: byte index at which an extra start is pulsed (-1 none);
  // timed: stream has no gaps, so the end-to-end cycle count is exact.
  task automatic run_load(input int sel, input logic [7:0] s[$], input int gap, input int stray,
                          input bit timed, input string tag);
    int w0, r0, d0, idx, guard, sc, lc, n, base, m, nw, ck, ed, oa, od;
    bit stray_done;
    logic v, st;
    w0 = nwr_of(sel); r0 = bad_rdy[sel]; d0 = ndone[sel];
    @(negedge clk); drv(sel, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    sc = cyc; lc = cyc; idx = 0; guard = 0; stray_done = 0;
    while (idx < s.size() && guard < 3000) begin
      v  = ($urandom_range(99) >= gap);
      st = (!stray_done && idx == stray);
      if (st) stray_done = 1;
      drv(sel, st, v, v ? s[idx] : 8'($urandom));
      if (v && rdy_of(sel)) begin idx++; lc = cyc + 1; end
      @(negedge clk); guard++;
    end
    // Keep junk valid while the load drains: none of it may be accepted.
    drv(sel, 1'b0, 1'b1, 8'($urandom));
    while (busy_of(sel) && guard < 3000) begin @(negedge clk); guard++; end
    drv(sel, 1'b0, 1'b0, 8'h00);
    chk({tag, "_timeout"}, 32'(guard >= 3000), 0);
    repeat (2) @(negedge clk);

    // Reference: words come straight from the stream, addresses from base modulo 2^W.
    n    = int'(s[0]) * 256 + int'(s[1]);
    base = (sel != 0) ? 14 : 0;
    m    = (sel != 0) ? 16 : 65536;
    nw   = nwr_of(sel) - w0;
    ck   = 0;
    chk({tag, "_nwrites"}, nw, n);
    for (int i = 0; i < n; i++) begin
      ed = int'(s[2 + 2 * i]) * 256 + int'(s[3 + 2 * i]);
      ck = ck ^ ed;
      if (i < nw) begin
        oa = (sel != 0) ? qa1[w0 + i] : qa0[w0 + i];
        od = (sel != 0) ? qd1[w0 + i] : qd0[w0 + i];
        chk({tag, "_addr"}, oa, (base + i) % m);
        chk({tag, "_data"}, od, ed);
      end
    end
    chk({tag, "_checksum"}, (sel != 0) ? b_ck : a_ck, ck);
    chk({tag, "_done_pulses"}, ndone[sel] - d0, 1);
    chk({tag, "_rdy_in_write"}, bad_rdy[sel] - r0, 0);
    chk({tag, "_done_time"}, done_cyc[sel], lc + ((n == 0) ? 0 : 1));
    if (n > 0) chk({tag, "_wren_time"}, wren_cyc[sel], lc);
    chk({tag, "_hold_fall"}, fall_cyc[sel], done_cyc[sel] + 1);
    if (timed) chk({tag, "_load_cycles"}, fall_cyc[sel] - sc + 1, 3 * n + 4);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 500000");
    $fatal(1);
  end

  logic [7:0] t2[$], t3[$], t6[$], sr[$];
  int w0, idx, guard, sel, n, gap, stray;

  initial begin
    rst = 1'b0;
    drv(0, 1'b0, 1'b0, 8'h00);
    drv(1, 1'b0, 1'b0, 8'h00);
    t2 = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
    t3 = '{8'h00, 8'h00};
    t6 = '{8'h00, 8'h03, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h04};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_addr", a_addr, 16'h0000);
    chk("rst_wren", a_wren, 0);
    chk("rst_ready", a_ready, 0);
    chk("rst_hold", a_hold, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_checksum", a_ck, 16'h0000);
    chk("rst_data", a_rdat, 16'h0000);
    chk("rst_b_addr", b_addr, 4'd14);
    rst = 1'b1;

    // No start: offered bytes must be ignored
    for (int i = 0; i < 6; i++) begin
      drv(0, 1'b0, 1'b1, 8'($urandom));
      @(negedge clk);
    end
    drv(0, 1'b0, 1'b0, 8'h00);
    chk("idle_nwrites", qa0.size(), 0);
    chk("idle_busy", a_busy, 0);
    chk("idle_addr", a_addr, 16'h0000);
    chk("idle_checksum", a_ck, 16'h0000);

    // Basic load
    run_load(0, t2, 0, -1, 1'b1, "basic");
    chk("basic_ck_const", a_ck, 16'hB9F8);

    // Zero length
    run_load(0, t3, 0, -1, 1'b1, "zero");
    chk("zero_ck_const", a_ck, 16'h0000);

    // Gapped streams
    run_load(0, t2, 40, -1, 1'b0, "gaps40");
    run_load(0, t2, 75, -1, 1'b0, "gaps75");
    chk("gaps_ck_const", a_ck, 16'hB9F8);

    // Reset after the first write
    w0 = qa0.size();
    @(negedge clk); drv(0, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    idx = 0; guard = 0;
    while (qa0.size() == w0 && guard < 100 && idx < t2.size()) begin
      drv(0, 1'b0, 1'b1, t2[idx]);
      if (a_ready) idx++;
      @(negedge clk); guard++;
    end
    chk("mid_reached_write", 32'(qa0.size() > w0), 1);
    rst = 1'b0;
    #1;
    chk("mid_wren", a_wren, 0);
    chk("mid_busy", a_busy, 0);
    chk("mid_hold", a_hold, 0);
    chk("mid_ready", a_ready, 0);
    chk("mid_done", a_done, 0);
    chk("mid_addr", a_addr, 16'h0000);
    chk("mid_checksum", a_ck, 16'h0000);
    chk("mid_data", a_rdat, 16'h0000);
    drv(0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    run_load(0, t2, 0, -1, 1'b1, "rerun");
    chk("rerun_ck_const", a_ck, 16'hB9F8);

    // Address wrap with a stray start pulse
    run_load(1, t6, 0, 3, 1'b1, "wrap");
    chk("wrap_ck_const", b_ck, 16'h0007);
    chk("wrap_last_addr", (qa1.size() > 0) ? qa1[qa1.size() - 1] : -1, 0);

    // Random loads on both instances
    for (int r = 0; r < 10; r++) begin
      sel   = r % 2;
      n     = (sel != 0) ? $urandom_range(0, 20) : $urandom_range(0, 8);
      mk_stream(n, sr);
      gap   = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(10, 60);
      stray = ($urandom_range(0, 2) == 0) ? $urandom_range(0, sr.size() - 1) : -1;
      run_load(sel, sr, gap, stray, gap == 0, $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
